// File: rtl/seq_divider.sv
// Iterative restoring divider: 2N-bit by N-bit unsigned, one quotient bit per clock.
// Divide-by-zero and quotient-overflow cases are resolved at start and finish in one cycle.
module seq_divider #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   shift_q, shift_d;
    logic [N-1:0]   dvsr_q, dvsr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quot_q, quot_d;
    logic [N-1:0]   remo_q, remo_d;
    logic           dbz_q, dbz_d;
    logic           ovf_q, ovf_d;

    logic [N:0]     trial_s;
    logic [N-1:0]   sub_s;
    logic           qbit_s;
    logic [N-1:0]   step_rem_s;
    logic [N-1:0]   step_shift_s;

    // One restoring step. The shift register feeds dividend bits out of its MSB
    // and takes quotient bits in at its LSB, so after N steps it holds the quotient.
    always_comb begin
        trial_s = {rem_q, shift_q[N-1]};
        // T < 2*divisor, so the difference always fits in N bits.
        sub_s   = trial_s[N-1:0] - dvsr_q;
        if (trial_s >= {1'b0, dvsr_q}) begin
            qbit_s     = 1'b1;
            step_rem_s = sub_s;
        end else begin
            qbit_s     = 1'b0;
            step_rem_s = trial_s[N-1:0];
        end
        step_shift_s = {shift_q[N-2:0], qbit_s};
    end

    // Next-state and result-load logic.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        shift_d = shift_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvsr_d = divisor;
                    if (divisor == {N{1'b0}}) begin
                        state_d = DONE;
                        quot_d  = {N{1'b1}};
                        remo_d  = dividend[N-1:0];
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b0;
                    end else if (dividend[2*N-1:N] >= divisor) begin
                        state_d = DONE;
                        quot_d  = {N{1'b1}};
                        remo_d  = {N{1'b0}};
                        dbz_d   = 1'b0;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = CALC;
                        rem_d   = dividend[2*N-1:N];
                        shift_d = dividend[N-1:0];
                        cnt_d   = {CW{1'b0}};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d   = step_rem_s;
                shift_d = step_shift_s;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    quot_d  = step_shift_s;
                    remo_d  = step_rem_s;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, working and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= {N{1'b0}};
            shift_q <= {N{1'b0}};
            dvsr_q  <= {N{1'b0}};
            cnt_q   <= {CW{1'b0}};
            quot_q  <= {N{1'b0}};
            remo_q  <= {N{1'b0}};
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            shift_q <= shift_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy        = (state_q == CALC);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
